// File: rtl/fdc_pkg.sv
// Shared types for the floppy-controller SD channel arbiter.
package fdc_pkg;

  localparam int FDC_MAX_DRV = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, XFER, GAP} arb_state_t;
  typedef logic [31:0] lba_t;
  typedef logic [$clog2(FDC_MAX_DRV)-1:0] drv_idx_t;

  // Reduce (last + offset) back into 0..num-1; the sum never reaches 2*num.
  function automatic drv_idx_t wrap_idx(input logic [2:0] sum, input logic [2:0] num);
    return drv_idx_t'((sum >= num) ? sum - num : sum);
  endfunction

endpackage

// File: rtl/fdc_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping modulo NUM_DRV.
module fdc_rr_pick
  import fdc_pkg::*;
#(
  parameter int NUM_DRV = 4
) (
  input  logic [NUM_DRV-1:0] req,
  input  logic [1:0]         last,
  output logic               valid,
  output logic [1:0]         idx
);

  logic [1:0]         cand [NUM_DRV];
  logic [NUM_DRV-1:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DRV; gi++) begin : g_cand
      // cand[0] is the drive right after 'last', cand[NUM_DRV-1] is 'last' itself
      assign cand[gi] = wrap_idx({1'b0, last} + 3'(gi + 1), 3'(NUM_DRV));
      assign hit[gi]  = req[cand[gi]];
    end
  endgenerate

  always_comb begin
    valid = |hit;
    idx   = '0;
    for (int k = NUM_DRV - 1; k >= 0; k--) begin
      if (hit[k]) begin
        idx = cand[k];
      end
    end
  end

endmodule

// File: rtl/fdc_sd_arbiter.sv
// Round-robin share of the host SD block channel among the fdc drives.
// Optional ISSUE watchdog with sticky timeout_err: define FDC_ARB_TIMEOUT_EN.
module fdc_sd_arbiter
  import fdc_pkg::*;
#(
  parameter int          NUM_DRV        = 4,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic [NUM_DRV-1:0]     drv_rd,
  input  logic [NUM_DRV-1:0]     drv_wr,
  input  logic [32*NUM_DRV-1:0]  drv_lba,
  input  logic [8*NUM_DRV-1:0]   drv_buff_din,
  output logic [NUM_DRV-1:0]     drv_ack,
  output logic [NUM_DRV-1:0]     drv_buff_wr,
  output logic [31:0]            sd_lba,
  output logic                   sd_rd,
  output logic                   sd_wr,
  input  logic                   sd_ack,
  input  logic                   sd_buff_wr,
  output logic [7:0]             sd_buff_din,
  output logic [1:0]             grant,
  output logic                   busy
`ifdef FDC_ARB_TIMEOUT_EN
  ,
  output logic                   timeout_err
`endif
);

  arb_state_t state_reg, state_next;
  drv_idx_t   grant_reg, grant_next;
  drv_idx_t   last_grant_reg, last_grant_next;
  drv_idx_t   pick_idx;
  lba_t       sd_lba_reg, sd_lba_next;
  logic       sd_rd_reg, sd_rd_next;
  logic       sd_wr_reg, sd_wr_next;
  logic       busy_reg;
  logic       pick_valid;
  logic       tmo_pulse;
  logic       ack_route;
  logic       xfer_route;

  logic [NUM_DRV-1:0] drv_req;
  lba_t               lba_arr [NUM_DRV];
  logic [7:0]         din_arr [NUM_DRV];

`ifdef FDC_ARB_TIMEOUT_EN
  logic [23:0] tmo_cnt_reg, tmo_cnt_next;
  logic        tmo_pulse_reg, tmo_pulse_next;
  logic        timeout_err_reg, timeout_err_next;
`endif

  assign drv_req = drv_rd | drv_wr;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DRV; gi++) begin : g_drv
      assign lba_arr[gi]     = drv_lba[32*gi +: 32];
      assign din_arr[gi]     = drv_buff_din[8*gi +: 8];
      assign drv_ack[gi]     = (grant_reg == drv_idx_t'(gi)) &&
                               ((ack_route && sd_ack) || tmo_pulse);
      assign drv_buff_wr[gi] = (grant_reg == drv_idx_t'(gi)) && xfer_route && sd_buff_wr;
    end
  endgenerate

  fdc_rr_pick #(
    .NUM_DRV (NUM_DRV)
  ) u_pick (
    .req   (drv_req),
    .last  (last_grant_reg),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // ISSUE is included so the drive sees ack on the very cycle it rises
  assign ack_route  = (state_reg == ISSUE) || (state_reg == XFER);
  assign xfer_route = (state_reg == XFER);

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    sd_lba_next     = sd_lba_reg;
    sd_rd_next      = sd_rd_reg;
    sd_wr_next      = sd_wr_reg;
`ifdef FDC_ARB_TIMEOUT_EN
    tmo_cnt_next     = tmo_cnt_reg;
    tmo_pulse_next   = 1'b0;
    timeout_err_next = timeout_err_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          grant_next  = pick_idx;
          sd_lba_next = lba_arr[pick_idx];
          sd_rd_next  = drv_rd[pick_idx];
          sd_wr_next  = drv_wr[pick_idx] && !drv_rd[pick_idx];
          state_next  = ISSUE;
`ifdef FDC_ARB_TIMEOUT_EN
          tmo_cnt_next = '0;
`endif
        end
      end
      ISSUE: begin
        if (sd_ack) begin
          sd_rd_next = 1'b0;
          sd_wr_next = 1'b0;
          state_next = XFER;
        end else if (!drv_req[grant_reg]) begin
          // withdrawn before the host answered: no turn is consumed
          sd_rd_next = 1'b0;
          sd_wr_next = 1'b0;
          state_next = IDLE;
        end
`ifdef FDC_ARB_TIMEOUT_EN
        else if (tmo_cnt_reg == TIMEOUT_CYCLES - 24'd1) begin
          sd_rd_next       = 1'b0;
          sd_wr_next       = 1'b0;
          tmo_pulse_next   = 1'b1;
          timeout_err_next = 1'b1;
          state_next       = GAP;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 24'd1;
        end
`endif
      end
      XFER: begin
        if (!sd_ack) begin
          state_next = GAP;
        end
      end
      GAP: begin
        last_grant_next = grant_reg;
        state_next      = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= drv_idx_t'(NUM_DRV - 1);
      sd_lba_reg     <= '0;
      sd_rd_reg      <= 1'b0;
      sd_wr_reg      <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      sd_lba_reg     <= sd_lba_next;
      sd_rd_reg      <= sd_rd_next;
      sd_wr_reg      <= sd_wr_next;
      busy_reg       <= (state_next != IDLE);
    end
  end

`ifdef FDC_ARB_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tmo_cnt_reg     <= '0;
      tmo_pulse_reg   <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      tmo_cnt_reg     <= tmo_cnt_next;
      tmo_pulse_reg   <= tmo_pulse_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  assign tmo_pulse   = tmo_pulse_reg;
  assign timeout_err = timeout_err_reg;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
  assign tmo_pulse      = 1'b0;
`endif

  assign sd_lba      = sd_lba_reg;
  assign sd_rd       = sd_rd_reg;
  assign sd_wr       = sd_wr_reg;
  assign grant       = grant_reg;
  assign busy        = busy_reg;
  assign sd_buff_din = din_arr[grant_reg];

endmodule

// File: tb/tb_fdc_sd_arbiter.sv
// Self-checking bench for fdc_sd_arbiter: vector table, hand sequences, random vs model.
module tb_fdc_sd_arbiter;

  localparam int N = 4;

  logic           CLK = 1'b0;
  logic           RESET_N;
  logic [N-1:0]   drv_rd, drv_wr, drv_ack, drv_buff_wr;
  logic [32*N-1:0] drv_lba;
  logic [8*N-1:0] drv_buff_din;
  logic [31:0]    sd_lba;
  logic           sd_rd, sd_wr, sd_ack, sd_buff_wr, busy;
  logic [7:0]     sd_buff_din;
  logic [1:0]     grant;
`ifdef FDC_ARB_TIMEOUT_EN
  logic           timeout_err;
`endif

  int checks   = 0;
  int failures = 0;
  int mdl_last = N - 1;
  int txn_no   = 0;

  always #5 CLK = ~CLK;

  fdc_sd_arbiter #(
    .NUM_DRV        (N),
    .TIMEOUT_CYCLES (24'd16)
  ) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .drv_rd       (drv_rd),
    .drv_wr       (drv_wr),
    .drv_lba      (drv_lba),
    .drv_buff_din (drv_buff_din),
    .drv_ack      (drv_ack),
    .drv_buff_wr  (drv_buff_wr),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_din  (sd_buff_din),
    .grant        (grant),
    .busy         (busy)
`ifdef FDC_ARB_TIMEOUT_EN
    ,
    .timeout_err  (timeout_err)
`endif
  );

  typedef struct {
    logic [N-1:0] rd;
    logic [N-1:0] wr;
    int           g;
    bit           is_rd;
    int           xlen;
    bit           fix_din;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arbitration: scan drives last+1, last+2, ... modulo N.
  function automatic int model_pick(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // Entry: just after an edge, DUT in IDLE, request vectors already set.
  // Exit: just after the GAP->IDLE edge.
  task automatic run_txn(input int exp_g, input bit exp_rd, input int xlen,
                         input bit stray, input bit fix_din);
    logic [31:0] lba_exp;
    bit          bw;
    lba_exp = drv_lba[32*exp_g +: 32];
    @(negedge CLK);
    chk("idle_busy", busy, 0);
    chk("idle_req", {sd_rd, sd_wr}, 0);
    @(posedge CLK);
    @(negedge CLK);
    chk("iss_grant", grant, exp_g);
    chk("iss_rd", sd_rd, exp_rd);
    chk("iss_wr", sd_wr, !exp_rd);
    chk("iss_lba", sd_lba, lba_exp);
    chk("iss_busy", busy, 1);
    chk("iss_ack0", drv_ack, 0);
    repeat ($urandom_range(0, 3)) begin
      @(posedge CLK);
      @(negedge CLK);
      chk("iss_hold", {sd_rd, sd_wr}, {exp_rd, !exp_rd});
    end
    @(posedge CLK); #1;
    sd_ack = 1'b1;
    @(negedge CLK);
    chk("iss_ackrise", drv_ack, 1 << exp_g);
    chk("iss_din", sd_buff_din, drv_buff_din[8*exp_g +: 8]);
    @(posedge CLK); #1;
    drv_rd[exp_g] = 1'b0;
    drv_wr[exp_g] = 1'b0;
    drv_lba[32*exp_g +: 32] = $urandom;
    for (int c = 0; c < xlen; c++) begin
      bw = 1'($urandom_range(0, 1));
      sd_buff_wr = bw;
      if (!fix_din) begin
        for (int i = 0; i < N; i++) drv_buff_din[8*i +: 8] = 8'($urandom);
      end
      @(negedge CLK);
      chk("xfer_ack", drv_ack, 1 << exp_g);
      chk("xfer_bwr", drv_buff_wr, bw ? (1 << exp_g) : 0);
      chk("xfer_din", sd_buff_din, drv_buff_din[8*exp_g +: 8]);
      chk("xfer_req", {sd_rd, sd_wr}, 0);
      chk("xfer_lba", sd_lba, lba_exp);
      @(posedge CLK); #1;
    end
    sd_ack = 1'b0;
    sd_buff_wr = 1'b0;
    @(negedge CLK);
    chk("xfer_ackfall", drv_ack, 0);
    @(posedge CLK); #1;
    sd_ack = stray;
    sd_buff_wr = stray;
    @(negedge CLK);
    chk("gap_busy", busy, 1);
    chk("gap_ack", drv_ack, 0);
    chk("gap_bwr", drv_buff_wr, 0);
    chk("gap_req", {sd_rd, sd_wr}, 0);
    @(posedge CLK); #1;
    sd_ack = 1'b0;
    sd_buff_wr = 1'b0;
    mdl_last = exp_g;
    $display("txn %0d: drive %0d %s lba=0x%08h xfer=%0d stray=%0d",
             txn_no, exp_g, exp_rd ? "rd" : "wr", lba_exp, xlen, stray);
    txn_no++;
  endtask

  task automatic rand_lbas();
    for (int i = 0; i < N; i++) drv_lba[32*i +: 32] = $urandom;
  endtask

  initial begin
    int g;
    logic [N-1:0] r, w;

    vecs[0] = '{4'b0010, 4'b0000, 1, 1'b1, 512, 1'b0};
    vecs[1] = '{4'b1111, 4'b0000, 2, 1'b1, 4,   1'b0};
    vecs[2] = '{4'b0001, 4'b0001, 0, 1'b1, 3,   1'b0};
    vecs[3] = '{4'b0000, 4'b0100, 2, 1'b0, 6,   1'b1};
    vecs[4] = '{4'b1001, 4'b0000, 3, 1'b1, 2,   1'b0};
    vecs[5] = '{4'b0000, 4'b0011, 0, 1'b0, 5,   1'b0};
    vecs[6] = '{4'b1000, 4'b0110, 1, 1'b0, 3,   1'b0};
    vecs[7] = '{4'b0101, 4'b0000, 2, 1'b1, 4,   1'b0};

    RESET_N = 1'b0;
    drv_rd = '0; drv_wr = '0; drv_lba = '0; drv_buff_din = '0;
    sd_ack = 1'b1; sd_buff_wr = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_rd", sd_rd, 0);
    chk("rst_wr", sd_wr, 0);
    chk("rst_lba", sd_lba, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", drv_ack, 0);
    chk("rst_bwr", drv_buff_wr, 0);
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
    RESET_N = 1'b1;
    mdl_last = N - 1;
    @(posedge CLK); #1;

    // table-driven transactions
    for (int v = 0; v < 8; v++) begin
      rand_lbas();
      if (v == 0) drv_lba[32*1 +: 32] = 32'h0000_0123;
      if (vecs[v].fix_din) drv_buff_din = 32'h00A5_0000;
      drv_rd = vecs[v].rd;
      drv_wr = vecs[v].wr;
      run_txn(vecs[v].g, vecs[v].is_rd, vecs[v].xlen, 1'(v % 2), vecs[v].fix_din);
    end

    // withdraw: last turn on drive 1, drive 3 wins then drops before ack
    drv_rd = 4'b0010; drv_wr = '0;
    run_txn(1, 1'b1, 2, 1'b0, 1'b0);
    drv_rd = 4'b1001;
    @(posedge CLK); #1;
    drv_rd = 4'b0101;
    @(negedge CLK);
    chk("wd_grant", grant, 3);
    chk("wd_issue", sd_rd, 1);
    chk("wd_ack", drv_ack, 0);
    @(posedge CLK); #1;
    g = model_pick(drv_rd | drv_wr, mdl_last);
    run_txn(g, 1'b1, 2, 1'b0, 1'b0);
    g = model_pick(drv_rd | drv_wr, mdl_last);
    run_txn(g, 1'b1, 2, 1'b0, 1'b0);

    // reset while the host is acking
    drv_rd = 4'b0100;
    @(posedge CLK); #1;
    sd_ack = 1'b1;
    @(posedge CLK); #1;
    drv_rd = '0;
    @(negedge CLK);
    chk("mid_xfer_ack", drv_ack, 4'b0100);
    @(posedge CLK); #1;
    RESET_N = 1'b0;
    #1;
    chk("mid_rst_rd", sd_rd, 0);
    chk("mid_rst_wr", sd_wr, 0);
    chk("mid_rst_ack", drv_ack, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_grant", grant, 0);
    #2;
    sd_ack = 1'b0;
    drv_rd = 4'b1000;
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    mdl_last = N - 1;
    run_txn(3, 1'b1, 3, 1'b0, 1'b0);

    // round robin with all drives requesting, then 0 and 2 again
    drv_rd = 4'b1111;
    for (int k = 0; k < 4; k++) run_txn(k, 1'b1, 2, 1'b0, 1'b0);
    drv_rd = 4'b0101;
    run_txn(0, 1'b1, 2, 1'b0, 1'b0);
    run_txn(2, 1'b1, 2, 1'b0, 1'b0);

    // randomized traffic against the reference model
    for (int it = 0; it < 40; it++) begin
      r = N'($urandom_range(0, 15));
      w = N'($urandom_range(0, 15));
      if ((r | w) == '0) r[$urandom_range(0, N - 1)] = 1'b1;
      rand_lbas();
      drv_rd = r;
      drv_wr = w;
      g = model_pick(r | w, mdl_last);
      run_txn(g, r[g], $urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'b0);
    end

`ifdef FDC_ARB_TIMEOUT_EN
    drv_rd = 4'b0001; drv_wr = '0;
    g = model_pick(drv_rd, mdl_last);
    @(posedge CLK); #1;
    for (int c = 0; c < 16; c++) begin
      @(negedge CLK);
      chk("to_wait_rd", sd_rd, 1);
      chk("to_wait_err", timeout_err, 0);
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    chk("to_rd", sd_rd, 0);
    chk("to_ack", drv_ack, 1 << g);
    chk("to_err", timeout_err, 1);
    @(posedge CLK); #1;
    drv_rd = '0;
    mdl_last = g;
    @(negedge CLK);
    chk("to_pulse_end", drv_ack, 0);
    chk("to_idle", busy, 0);
    chk("to_sticky", timeout_err, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: run did not complete, time limit %0t reached", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fdc_sd_arbiter.md
Name: fdc_sd_arbiter

Overview:
- Shares one host SD block channel between the four per-drive wd1793 instances of the floppy controller.
- Each drive raises sd_rd/sd_wr with its LBA. The arbiter grants one drive at a time in round-robin order and drives the single host request.
- It routes sd_ack and sd_buff_wr back to the granted drive only, and muxes that drive's sd_buff_din onto the host byte bus.
- Sits between the fdc drive array and the hps_io block-device port.

Parameters:
- NUM_DRV, 4, number of requesting drives (2..4).
- TIMEOUT_CYCLES, 24'd10_000_000, CLK cycles allowed without host sd_ack before abort (used only with the optional feature).

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RESET_N  in  1  reset: RESET_N, asynchronous, active-low.
- drv_rd  in  NUM_DRV  per-drive read request, level, held until its ack rises.
- drv_wr  in  NUM_DRV  per-drive write request, level.
- drv_lba  in  32*NUM_DRV  per-drive LBA; drive i occupies bits [32i+31:32i].
- drv_buff_din  in  8*NUM_DRV  per-drive write-buffer byte.
- drv_ack  out  NUM_DRV  per-drive ack; only the granted bit follows sd_ack.
- drv_buff_wr  out  NUM_DRV  per-drive buffer write strobe.
- sd_lba  out  32  host LBA, latched at grant.
- sd_rd  out  1  host read request.
- sd_wr  out  1  host write request.
- sd_ack  in  1  host ack.
- sd_buff_wr  in  1  host buffer write strobe.
- sd_buff_din  out  8  byte to host, muxed from the granted drive.
- grant  out  2  index of the granted drive (diagnostics).
- busy  out  1  high in every state except IDLE.

Behaviour:
- All outputs are registered except drv_ack, drv_buff_wr and sd_buff_din, which are combinational muxes on grant and state.
- Reset values:
  - sd_rd=0, sd_wr=0, sd_lba=0, grant=0, busy=0.
  - drv_ack=0, drv_buff_wr=0.
  - State=IDLE; last_grant=NUM_DRV-1, so drive 0 wins first.
- State machine:
  - IDLE:
    - Search starts at last_grant+1 and wraps modulo NUM_DRV.
    - The first drive i with drv_rd[i]|drv_wr[i] is granted.
    - On grant: latch grant=i, sd_lba=drv_lba[i], op (rd takes priority if both rd and wr are set); go to ISSUE.
    - sd_rd or sd_wr is asserted on the next edge. Latency from request seen to host request is 1 cycle.
  - ISSUE:
    - sd_rd/sd_wr held high.
    - On sd_ack=1: deassert sd_rd/sd_wr and go to XFER.
    - If the granted drive drops both requests before ack: deassert and go to IDLE. last_grant is unchanged.
  - XFER:
    - drv_ack[grant]=sd_ack.
    - drv_buff_wr[grant]=sd_buff_wr.
    - sd_buff_din=drv_buff_din[grant].
    - On sd_ack=0: go to GAP.
  - GAP: one cycle, all requests low; last_grant<=grant; go to IDLE.
- Routing outside XFER:
  - drv_ack and drv_buff_wr are all 0 in IDLE, ISSUE and GAP, except that drv_ack[grant] also mirrors sd_ack in the ISSUE cycle where ack rises.
  - sd_buff_din=drv_buff_din[grant] in every state.
- Ignored inputs:
  - A stray sd_ack in IDLE or GAP is ignored.
  - Requests from non-granted drives are held off; they are never lost because drives hold them as levels.
- Fairness: a drive continuously requesting waits at most NUM_DRV-1 full transfers.
- Reset mid-transfer: everything returns to reset values immediately. The host sees sd_rd/sd_wr fall asynchronously.
- Drive indices ≥ NUM_DRV are never granted.

Optional Feature:
- FDC_ARB_TIMEOUT_EN defined:
  - A 24-bit counter clears on entering ISSUE and increments each cycle in ISSUE.
  - On reaching TIMEOUT_CYCLES: deassert sd_rd/sd_wr, pulse drv_ack[grant] high for one cycle so the wd1793 unblocks, go to GAP, and set the sticky status bit timeout_err.
  - timeout_err is an extra 1-bit output port, cleared only by reset.
- Not defined: no counter and no timeout_err port; ISSUE waits indefinitely.

Decomposition:
- Package fdc_pkg:
  - typedef enum logic [1:0] arb_state_t {IDLE, ISSUE, XFER, GAP}.
  - localparam FDC_MAX_DRV=4.
  - typedef logic [31:0] lba_t.
- One sub-module, fdc_rr_pick: combinational round-robin picker. Inputs: req[NUM_DRV], last[1:0]. Outputs: valid, idx[1:0].

Test Plan:
- Single read: drv_rd[1]=1, lba=0x0000_0123.
  - Next cycle: sd_rd=1, sd_lba=0x123, grant=1.
  - Host ack high for 512 cycles: drv_ack[1] mirrors it and the other drv_ack bits stay 0.
  - After ack falls: one GAP cycle, then IDLE.
- Round robin: drv_rd=4'b1111 held, each request dropped after its ack.
  - Grant order 0,1,2,3.
  - Re-raise drv_rd[0], drv_rd[2] after drive 3 completes: order 0,2.
- Write mux: drv_wr[2]=1 with drv_buff_din[2]=0xA5 and other drives at 0x00.
  - During XFER: sd_buff_din=0xA5, sd_wr fell when ack rose.
  - sd_buff_wr pulses appear only on drv_buff_wr[2].
- Withdraw: drv_rd[3] raised, then dropped during ISSUE before ack.
  - sd_rd falls next cycle and the state returns to IDLE.
  - A pending drv_rd[0] is granted next.
- Reset mid-XFER: assert RESET_N=0 while sd_ack=1.
  - sd_rd, sd_wr, drv_ack and busy are 0 immediately.
  - After release with drv_rd=4'b1000: grant=3.
- With FDC_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: drv_rd[0] raised, no host ack.
  - After 16 cycles: sd_rd=0, drv_ack[0] pulses for 1 cycle, timeout_err=1.
